// File: rtl/alu_arbiter_if.sv
// Bundles the two-requester operation/response handshakes and the shared ALU
// connection of the alu_arbiter block.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [7:0]         req_ctrl;
  logic [1:0]         resp_valid;
  logic [1:0]         resp_ready;
  logic [WIDTH-1:0]   resp_result;
  logic               resp_zero;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [3:0]         alu_ctrl;
  logic [WIDTH-1:0]   alu_out;
  logic               alu_zero;

  modport slave (
    input  req_valid, req_a, req_b, req_ctrl, resp_ready, alu_out, alu_zero,
    output req_ready, resp_valid, resp_result, resp_zero, alu_a, alu_b, alu_ctrl
  );

  modport master (
    output req_valid, req_a, req_b, req_ctrl, resp_ready, alu_out, alu_zero,
    input  req_ready, resp_valid, resp_result, resp_zero, alu_a, alu_b, alu_ctrl
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter giving two requesters time-shared access to one
// combinational ALU: accept, execute for one cycle, then hold the response.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus,
  output logic         busy,
  output logic [15:0]  op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             last_grant;
  logic             gnt;
  logic             grant_sel;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       ctrl_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic [1:0]       resp_valid_q;
  logic [15:0]      op_count_q;

  // Under contention the requester that did not win last time is chosen.
  always_comb begin
    grant_sel = bus.req_valid[1];
    if (bus.req_valid == 2'b11) grant_sel = ~last_grant;
    bus.req_ready = 2'b00;
    if (state == IDLE && bus.req_valid != 2'b00)
      bus.req_ready = grant_sel ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      gnt          <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      ctrl_q       <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      resp_valid_q <= 2'b00;
      op_count_q   <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid != 2'b00) begin
            gnt    <= grant_sel;
            a_q    <= grant_sel ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
            b_q    <= grant_sel ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
            ctrl_q <= grant_sel ? bus.req_ctrl[7:4] : bus.req_ctrl[3:0];
            state  <= EXEC;
          end
        end
        EXEC: begin
          result_q     <= bus.alu_out;
          zero_q       <= bus.alu_zero;
          resp_valid_q <= gnt ? 2'b10 : 2'b01;
          state        <= RESP;
        end
        RESP: begin
          if (bus.resp_ready[gnt]) begin
            last_grant   <= gnt;
            op_count_q   <= op_count_q + 16'd1;
            resp_valid_q <= 2'b00;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.alu_ctrl    = ctrl_q;
  assign bus.resp_result = result_q;
  assign bus.resp_zero   = zero_q;
  assign bus.resp_valid  = resp_valid_q;
  assign busy            = (state != IDLE);
  assign op_count        = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a transaction-level model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        busy;
  logic [15:0] op_count;

  int vectors = 0;
  int fails   = 0;

  alu_arbiter_if #(.WIDTH(32)) bus();

  alu_arbiter #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  // Team ALU: codes beyond XOR are undecoded and return zero.
  function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [3:0] c);
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  assign bus.alu_out  = alu_fn(bus.alu_a, bus.alu_b, bus.alu_ctrl);
  assign bus.alu_zero = (bus.alu_out == 32'd0);

  // Model: cycles since accept (0 = idle, 1 = executing, 2 = responding).
  int          m_phase;
  int          m_last;
  int          m_g;
  int          m_count;
  logic [31:0] m_a, m_b, m_res;
  logic [3:0]  m_ctrl;
  logic        m_zero;

  function automatic int exp_grant(logic [1:0] v);
    if (v == 2'b11) return 1 - m_last;
    return v[1] ? 1 : 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    int g;
    if (reset) begin
      m_phase <= 0; m_last <= 1; m_g <= 0; m_count <= 0;
      m_a <= '0; m_b <= '0; m_ctrl <= '0; m_res <= '0; m_zero <= 1'b0;
    end else if (m_phase == 0) begin
      if (bus.req_valid != 2'b00) begin
        g = exp_grant(bus.req_valid);
        m_g    <= g;
        m_a    <= bus.req_a[g*32 +: 32];
        m_b    <= bus.req_b[g*32 +: 32];
        m_ctrl <= bus.req_ctrl[g*4 +: 4];
        m_res  <= alu_fn(bus.req_a[g*32 +: 32], bus.req_b[g*32 +: 32], bus.req_ctrl[g*4 +: 4]);
        m_zero <= (alu_fn(bus.req_a[g*32 +: 32], bus.req_b[g*32 +: 32], bus.req_ctrl[g*4 +: 4]) == 32'd0);
        m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      m_phase <= 2;
    end else if (bus.resp_ready[m_g]) begin
      m_last  <= m_g;
      m_count <= (m_count + 1) % 65536;
      m_phase <= 0;
    end
  end

  task automatic check_output(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [1:0] er;
    er = 2'b00;
    if (m_phase == 0 && bus.req_valid != 2'b00)
      er = (exp_grant(bus.req_valid) == 1) ? 2'b10 : 2'b01;
    check_output("req_ready", 64'(bus.req_ready), 64'(er));
    check_output("resp_valid", 64'(bus.resp_valid),
                 (m_phase == 2) ? ((m_g == 1) ? 64'd2 : 64'd1) : 64'd0);
    check_output("busy", 64'(busy), (m_phase != 0) ? 64'd1 : 64'd0);
    check_output("op_count", 64'(op_count), 64'(m_count));
    check_output("alu_a", 64'(bus.alu_a), 64'(m_a));
    check_output("alu_b", 64'(bus.alu_b), 64'(m_b));
    check_output("alu_ctrl", 64'(bus.alu_ctrl), 64'(m_ctrl));
    if (m_phase == 2 || reset) begin
      check_output("resp_result", 64'(bus.resp_result), reset ? 64'd0 : 64'(m_res));
      check_output("resp_zero", 64'(bus.resp_zero), reset ? 64'd0 : 64'(m_zero));
    end
  end

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (bus.resp_valid != 2'b00) ok = 1'b1;
    end
    if (!ok) check_output("resp_timeout", 64'd0, 64'd1);
  endtask

  task automatic apply_stimulus(int i, logic [31:0] a, logic [31:0] b, logic [3:0] c, output bit ok);
    bus.req_a[i*32 +: 32] = a;
    bus.req_b[i*32 +: 32] = b;
    bus.req_ctrl[i*4 +: 4] = c;
    bus.req_valid = (i == 1) ? 2'b10 : 2'b01;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    wait_resp(ok);
  endtask

  initial begin
    bit ok;
    int got;
    bus.req_valid  = 2'b00;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_ctrl   = '0;
    bus.resp_ready = 2'b11;

    #1 reset = 1'b1;
    @(negedge clk);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_op_count", 64'(op_count), 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Single request: 5 - 3.
    @(posedge clk); #1;
    apply_stimulus(0, 32'd5, 32'd3, 4'b0001, ok);
    check_output("single_valid", 64'(bus.resp_valid), 64'd1);
    check_output("single_result", 64'(bus.resp_result), 64'd2);
    check_output("single_zero", 64'(bus.resp_zero), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_output("single_count", 64'(op_count), 64'd1);

    // Asynchronous reset while the operation is executing.
    @(posedge clk); #1;
    bus.req_a[31:0] = 32'd11; bus.req_b[31:0] = 32'd4; bus.req_ctrl[3:0] = 4'd0;
    bus.req_valid = 2'b01;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    #2 reset = 1'b1;
    #1;
    check_output("abort_busy", 64'(busy), 64'd0);
    check_output("abort_valid", 64'(bus.resp_valid), 64'd0);
    check_output("abort_count", 64'(op_count), 64'd0);
    @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;

    // Contention after reset: grants alternate starting with requester 0.
    bus.req_a = {32'h0000_00F0, 32'd7};
    bus.req_b = {32'h0000_000F, 32'd9};
    bus.req_ctrl = {4'b0010, 4'b0000};
    bus.req_valid = 2'b11;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      if (bus.resp_valid != 2'b00) begin
        check_output($sformatf("cont_grant%0d", got), 64'(bus.resp_valid),
                     (got % 2 == 0) ? 64'd1 : 64'd2);
        check_output($sformatf("cont_result%0d", got), 64'(bus.resp_result),
                     (got % 2 == 0) ? 64'd16 : 64'd0);
        check_output($sformatf("cont_zero%0d", got), 64'(bus.resp_zero),
                     (got % 2 == 0) ? 64'd0 : 64'd1);
        got++;
      end
    end
    if (got < 4) check_output("cont_timeout", 64'(got), 64'd4);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;

    // Backpressure on requester 1; a transient request and a stray ready are ignored.
    bus.resp_ready = 2'b00;
    @(posedge clk); #1;
    apply_stimulus(1, 32'd100, 32'd1, 4'b0001, ok);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output($sformatf("bp_valid%0d", i), 64'(bus.resp_valid), 64'd2);
      check_output($sformatf("bp_result%0d", i), 64'(bus.resp_result), 64'd99);
      check_output($sformatf("bp_ready%0d", i), 64'(bus.req_ready), 64'd0);
      check_output($sformatf("bp_busy%0d", i), 64'(busy), 64'd1);
      @(posedge clk); #1;
      if (i == 1) begin bus.req_valid = 2'b01; bus.resp_ready = 2'b01; end
      if (i == 3) bus.req_valid = 2'b00;
    end
    bus.resp_ready = 2'b10;
    @(posedge clk); #1;
    bus.resp_ready = 2'b11;
    @(negedge clk);
    check_output("bp_count", 64'(op_count), 64'd5);

    // Undecoded control code.
    @(posedge clk); #1;
    apply_stimulus(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1111, ok);
    check_output("undec_result", 64'(bus.resp_result), 64'd0);
    check_output("undec_zero", 64'(bus.resp_zero), 64'd1);
    @(posedge clk); #1;

    // Counter wrap from 0xFFFF.
    force dut.op_count_q = 16'hFFFF;
    m_count = 65535;
    #1 release dut.op_count_q;
    @(negedge clk);
    check_output("wrap_pre", 64'(op_count), 64'hFFFF);
    @(posedge clk); #1;
    apply_stimulus(1, 32'd1, 32'd2, 4'b0011, ok);
    check_output("wrap_result", 64'(bus.resp_result), 64'd3);
    @(posedge clk); #1;
    @(negedge clk);
    check_output("wrap_count", 64'(op_count), 64'd0);

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
